// File: rtl/m6809_uart_pkg.sv
// Shared constants and FSM encoding for the 6809 transmit-only UART.
// M6809_UART_TX_PARITY_EN adds the PARITY state between DATA and STOP.
package m6809_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_IRQ   = 7;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;
    localparam int CTRL_PE = 2;

`ifdef M6809_UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
`endif

endpackage

// File: rtl/m6809_sync_fifo.sv
// Synchronous FIFO, head visible combinationally; push when full is dropped
// unless a pop happens in the same cycle. Pointers carry an extra wrap bit.
module m6809_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= wdata;
                wr_q <= wr_q + PTR_ONE;
            end
            if (do_pop) rd_q <= rd_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/m6809_uart.sv
// Memory-mapped 8N1 transmit UART: byte writes queue in a FIFO and pop one cycle later
// when idle and enabled; a full FIFO drops writes and sets OVF. Option: M6809_UART_TX_PARITY_EN.
module m6809_uart_tx
    import m6809_uart_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] DEFAULT_DIV = 8'd15
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       sel,
    input  logic [1:0] a,
    input  logic       data_rw_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       tx,
    output logic       irq_b
);

    uart_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  baud_q, baud_d;
    logic [7:0]  div_q, div_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        ovf_q, ovf_d;
    logic        tx_q, tx_d;
    logic        irq_b_q, irq_b_d;
    logic        par_q, par_d;

    logic       wr_en, push, pop, busy, tick;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_rdata, status;

    assign wr_en = sel && !data_rw_n;
    assign push  = wr_en && (a == REG_DATA);
    assign busy  = (state_q != S_IDLE);
    assign tick  = (baud_q == 8'd0);
    assign tx    = tx_q;
    assign irq_b = irq_b_q;

    m6809_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .push    (push),
        .pop     (pop),
        .wdata   (din),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        ctrl_d = ctrl_q;
        div_d  = div_q;
        ovf_d  = ovf_q;
        if (wr_en && a == REG_CTRL) begin
`ifdef M6809_UART_TX_PARITY_EN
            ctrl_d = din[2:0];
`else
            ctrl_d = {1'b0, din[1:0]};
`endif
        end
        if (wr_en && a == REG_DIV) div_d = din;
        // A pop in the same cycle frees the slot, so that push is not an overflow.
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        else if (wr_en && a == REG_STATUS && din[ST_OVF]) ovf_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = tick ? div_q : baud_q - 8'd1;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                baud_d = baud_q;
                if (ctrl_q[CTRL_EN] && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    par_d   = ^fifo_rdata;
                    bit_d   = 3'd0;
                    baud_d  = div_q;
                    state_d = S_START;
                end
            end
            S_START: if (tick) state_d = S_DATA;
            S_DATA: if (tick) begin
                shift_d = {1'b0, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
`ifdef M6809_UART_TX_PARITY_EN
                    state_d = ctrl_q[CTRL_PE] ? S_PARITY : S_STOP;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef M6809_UART_TX_PARITY_EN
            S_PARITY: if (tick) state_d = S_STOP;
`endif
            S_STOP: if (tick) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // tx is registered from the next state so it changes on the same edge as the FSM.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef M6809_UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase

        irq_b_d = ~(ctrl_q[CTRL_IE] && fifo_empty && !busy);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            shift_q <= 8'd0;
            bit_q   <= 3'd0;
            baud_q  <= 8'd0;
            div_q   <= DEFAULT_DIV;
            ctrl_q  <= 3'd0;
            ovf_q   <= 1'b0;
            tx_q    <= 1'b1;
            irq_b_q <= 1'b1;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            ctrl_q  <= ctrl_d;
            ovf_q   <= ovf_d;
            tx_q    <= tx_d;
            irq_b_q <= irq_b_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        status           = 8'h00;
        status[ST_BUSY]  = busy;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf_q;
        status[ST_IRQ]   = ~irq_b_q;
        dout = 8'h00;
        if (sel) begin
            case (a)
                REG_STATUS: dout = status;
                REG_CTRL:   dout = {5'd0, ctrl_q};
                REG_DIV:    dout = div_q;
                default:    dout = 8'h00;
            endcase
        end
    end

endmodule
